spi_cmd_ctrl: RTL and testbench
===============================

Name: spi_cmd_ctrl

Overview:
Command/transaction controller behind the SPI slave byte interface in the phase_2xRx_bitdump design. It parses the received byte stream into register read/write bursts, bitdump FIFO drains and status clears. It drives the register bus and the FIFO read port, and keeps the next MISO byte staged on the slave's TX input. A transaction is one CS_n-low frame. The first byte is the command; the remaining bytes are address and data.

Parameters:
FILL_BYTE, 8'h00, byte transmitted on a dump slot when the FIFO is empty.
STATUS_SIG, 4'hA, constant signature in status bits 7:4.

Ports:
i_Clk  in  1  system clock; all logic is on the rising edge.
i_Rst  in  1  reset; synchronous, active-high.
i_RX_DV  in  1  one-cycle pulse from the SPI slave: i_RX_Byte is valid.
i_RX_Byte  in  8  received byte.
o_TX_Byte  out  8  next MISO byte; the slave samples it on the same edge that it raises i_RX_DV.
i_SPI_CS_n  in  1  raw chip select, asynchronous; synchronized internally.
o_Reg_Addr  out  8  register bus address.
o_Reg_Wr_En  out  1  one-cycle write strobe.
o_Reg_Wr_Data  out  8  write data.
o_Reg_Rd_En  out  1  one-cycle read strobe; i_Reg_Rd_Data is valid exactly 1 cycle later.
i_Reg_Rd_Data  in  8  read data.
o_Fifo_Rd_En  out  1  one-cycle pop; i_Fifo_Data is valid exactly 1 cycle later.
i_Fifo_Data  in  8  bitdump FIFO data.
i_Fifo_Empty  in  1  FIFO empty flag.
o_Busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: every output is 0; state IDLE; sticky flags cleared; the CS synchronizer is preset to 1.
- CS handling:
  - i_SPI_CS_n passes through a 2-FF synchronizer (cs_s).
  - cs_s=1 forces state IDLE on the next cycle from any state.
  - If i_RX_DV and cs_s=1 occur in the same cycle, the byte is processed first (a write still commits), then the state becomes IDLE.
- Status byte = {STATUS_SIG, 1'b0, bad_cmd, underrun, i_Fifo_Empty}.
- In IDLE, o_TX_Byte is reloaded with the status byte every cycle.
- All outputs are registered. Strobes assert in the cycle after the i_RX_DV that triggers them.
- MISO slot rule: a value loaded into o_TX_Byte while processing byte k is shifted out during byte k+2. The controller must finish any update within 3 cycles of i_RX_DV (the slave clock is at least 4x slower, so a byte takes at least 32 cycles).
- States and transitions:
  - IDLE: on i_RX_DV, decode the command byte.
    - 0x00 NOP -> IGNORE.
    - 0x01 READ -> ADDR (read).
    - 0x02 WRITE -> ADDR (write).
    - 0x03 DUMP -> DUMP, and perform a pop.
    - 0x04 CLR -> clear underrun and bad_cmd on the next cycle, then IGNORE.
    - Any other value -> set bad_cmd, then IGNORE.
  - ADDR: on i_RX_DV, latch addr = byte.
    - Read mode: issue o_Reg_Rd_En with o_Reg_Addr = addr; load o_TX_Byte <= i_Reg_Rd_Data in the response cycle; go to RD_STREAM.
    - Write mode: go to WR_STREAM.
  - RD_STREAM: on each i_RX_DV, addr <= addr+1, issue a read, load o_TX_Byte with the result.
    - Result: MISO byte 3+n = reg[A+n].
    - MISO byte 2 = status, loaded on command-byte processing.
  - WR_STREAM: on each i_RX_DV, o_Reg_Wr_En=1 for one cycle with the current addr and the byte, then addr <= addr+1. Data byte n goes to A+n.
  - DUMP: on command-byte processing and on every later i_RX_DV:
    - If !i_Fifo_Empty: o_Fifo_Rd_En pulse; o_TX_Byte <= i_Fifo_Data the next cycle.
    - Else: o_TX_Byte <= FILL_BYTE and set underrun; no pop.
    - MISO byte 2+n = D_n.
  - IGNORE: i_RX_DV has no effect until CS rises.
- Address arithmetic is 8-bit and wraps: 0xFF + 1 = 0x00.
- Sticky flags are cleared only by the CLR command or by reset.
- A reset during a transaction aborts it with no strobe; the rest of that frame is ignored.
- An i_RX_DV arriving while a prior read or pop response is pending cannot happen by construction. The next byte's i_RX_DV is at least 32 cycles away, so no queueing is needed.
- The register bus and the FIFO are never strobed while state is IDLE or IGNORE.

Test Plan:
- Write burst: CS low, send 02 10 AA BB CC, CS high -> three single-cycle writes: 0x10=AA, 0x11=BB, 0x12=CC; no strobes after CS rises.
- Read burst: preload reg[0xFE]=11, reg[0xFF]=22, reg[0x00]=33; send 01 FE 00 00 00 00 -> MISO bytes 2..5 = status (0xA0 with FIFO non-empty), 11, 22, 33. Confirms address wrap.
- Dump with underrun: FIFO holds 5A, 3C; send 03 then 4 dummy bytes -> MISO bytes 2..4 = 5A, 3C, 00; exactly 2 pops; underrun=1; idle status reads 0xA3 with the FIFO empty.
- Clear plus bad command: send 7F, toggle CS, send 04, toggle CS -> after the first frame the status has bit2 set; after the second, bits 2:1 = 0.
- Abort: send 02 20 then raise CS mid-byte; apply reset during a later 02 frame -> no write strobes after CS rises; all outputs 0 after reset; the next frame decodes its first byte as a command.
- Simultaneous events: the last write byte's i_RX_DV coincides with cs_s=1 -> the write commits, state is IDLE one cycle later, o_Busy=0.

Source files
------------

// File: rtl/spi_cmd_ctrl.sv
// Command/transaction controller behind the SPI slave byte interface.
// Parses CS_n-framed byte streams into register read/write bursts, bitdump
// FIFO drains and status clears, and keeps the next MISO byte staged.
module spi_cmd_ctrl #(
  parameter logic [7:0] FILL_BYTE  = 8'h00,
  parameter logic [3:0] STATUS_SIG = 4'hA
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_TX_Byte,
  input  logic       i_SPI_CS_n,
  output logic [7:0] o_Reg_Addr,
  output logic       o_Reg_Wr_En,
  output logic [7:0] o_Reg_Wr_Data,
  output logic       o_Reg_Rd_En,
  input  logic [7:0] i_Reg_Rd_Data,
  output logic       o_Fifo_Rd_En,
  input  logic [7:0] i_Fifo_Data,
  input  logic       i_Fifo_Empty,
  output logic       o_Busy
);

  typedef enum logic [2:0] {
    StIdle,
    StIgnore,
    StAddr,
    StRdStream,
    StWrStream,
    StDump
  } t_state;

  localparam logic [7:0] CmdNop   = 8'h00;
  localparam logic [7:0] CmdRead  = 8'h01;
  localparam logic [7:0] CmdWrite = 8'h02;
  localparam logic [7:0] CmdDump  = 8'h03;
  localparam logic [7:0] CmdClr   = 8'h04;

  t_state     r_state, w_state_next;
  logic       r_cs_meta, r_cs_s;
  logic [1:0] r_cs_vld;
  logic       r_armed;
  logic       r_wr_mode, w_wr_mode;
  logic [7:0] r_addr, w_addr;
  logic       r_bad_cmd, w_bad_cmd;
  logic       r_underrun, w_underrun;
  logic       r_rd_resp, r_pop_resp;
  logic [7:0] r_tx_byte, w_tx_byte;
  logic [7:0] r_reg_addr, w_reg_addr;
  logic       r_wr_en, w_wr_en;
  logic [7:0] r_wr_data, w_wr_data;
  logic       r_rd_en, w_rd_en;
  logic       r_fifo_rd_en, w_fifo_rd_en;
  logic       r_busy;
  logic [7:0] w_status;

  assign w_status = {STATUS_SIG, 1'b0, r_bad_cmd, r_underrun, i_Fifo_Empty};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    w_state_next = r_state;
    w_wr_mode    = r_wr_mode;
    w_addr       = r_addr;
    w_bad_cmd    = r_bad_cmd;
    w_underrun   = r_underrun;
    w_tx_byte    = r_tx_byte;
    w_reg_addr   = r_reg_addr;
    w_wr_en      = 1'b0;
    w_wr_data    = r_wr_data;
    w_rd_en      = 1'b0;
    w_fifo_rd_en = 1'b0;

    if (r_state == StIdle) w_tx_byte = w_status;
    // Read/pop responses are valid one cycle after the strobe.
    if (r_rd_resp)  w_tx_byte = i_Reg_Rd_Data;
    if (r_pop_resp) w_tx_byte = i_Fifo_Data;

    if (i_RX_DV) begin
      case (r_state)
        StIdle: begin
          // Unarmed after reset until CS is seen high: rest of an aborted frame is dropped.
          if (r_armed) begin
            case (i_RX_Byte)
              CmdNop:   w_state_next = StIgnore;
              CmdRead: begin
                w_state_next = StAddr;
                w_wr_mode    = 1'b0;
              end
              CmdWrite: begin
                w_state_next = StAddr;
                w_wr_mode    = 1'b1;
              end
              CmdDump: begin
                w_state_next = StDump;
                if (!i_Fifo_Empty) begin
                  w_fifo_rd_en = 1'b1;
                end else begin
                  w_tx_byte  = FILL_BYTE;
                  w_underrun = 1'b1;
                end
              end
              CmdClr: begin
                w_state_next = StIgnore;
                w_bad_cmd    = 1'b0;
                w_underrun   = 1'b0;
              end
              default: begin
                w_state_next = StIgnore;
                w_bad_cmd    = 1'b1;
              end
            endcase
          end
        end
        StAddr: begin
          w_addr     = i_RX_Byte;
          w_reg_addr = i_RX_Byte;
          if (r_wr_mode) begin
            w_state_next = StWrStream;
          end else begin
            w_rd_en      = 1'b1;
            w_state_next = StRdStream;
          end
        end
        StRdStream: begin
          w_addr     = r_addr + 8'd1;
          w_reg_addr = r_addr + 8'd1;
          w_rd_en    = 1'b1;
        end
        StWrStream: begin
          w_wr_en    = 1'b1;
          w_reg_addr = r_addr;
          w_wr_data  = i_RX_Byte;
          w_addr     = r_addr + 8'd1;
        end
        StDump: begin
          if (!i_Fifo_Empty) begin
            w_fifo_rd_en = 1'b1;
          end else begin
            w_tx_byte  = FILL_BYTE;
            w_underrun = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // CS high ends the frame after any coincident byte has been handled.
    if (r_cs_s) w_state_next = StIdle;
  end

  // State, CS synchronizer and output registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state      <= StIdle;
      r_cs_meta    <= 1'b1;
      r_cs_s       <= 1'b1;
      r_cs_vld     <= 2'b00;
      r_armed      <= 1'b0;
      r_wr_mode    <= 1'b0;
      r_addr       <= 8'h00;
      r_bad_cmd    <= 1'b0;
      r_underrun   <= 1'b0;
      r_rd_resp    <= 1'b0;
      r_pop_resp   <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_reg_addr   <= 8'h00;
      r_wr_en      <= 1'b0;
      r_wr_data    <= 8'h00;
      r_rd_en      <= 1'b0;
      r_fifo_rd_en <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cs_meta    <= i_SPI_CS_n;
      r_cs_s       <= r_cs_meta;
      // r_cs_vld[1] marks that r_cs_s holds a real sample, not the reset preset.
      r_cs_vld     <= {r_cs_vld[0], 1'b1};
      r_armed      <= r_armed | (r_cs_vld[1] & r_cs_s);
      r_wr_mode    <= w_wr_mode;
      r_addr       <= w_addr;
      r_bad_cmd    <= w_bad_cmd;
      r_underrun   <= w_underrun;
      r_rd_resp    <= r_rd_en;
      r_pop_resp   <= r_fifo_rd_en;
      r_tx_byte    <= w_tx_byte;
      r_reg_addr   <= w_reg_addr;
      r_wr_en      <= w_wr_en;
      r_wr_data    <= w_wr_data;
      r_rd_en      <= w_rd_en;
      r_fifo_rd_en <= w_fifo_rd_en;
      r_busy       <= (w_state_next != StIdle);
    end
  end

  assign o_TX_Byte     = r_tx_byte;
  assign o_Reg_Addr    = r_reg_addr;
  assign o_Reg_Wr_En   = r_wr_en;
  assign o_Reg_Wr_Data = r_wr_data;
  assign o_Reg_Rd_En   = r_rd_en;
  assign o_Fifo_Rd_En  = r_fifo_rd_en;
  assign o_Busy        = r_busy;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: register bus and FIFO models, byte-level
// SPI slave emulation (MISO byte k+1 = o_TX_Byte sampled at byte k's RX_DV).
module tb_spi_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       cs_n;
  logic [7:0] tx_byte;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data;
  logic       fifo_rd_en;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       busy;

  spi_cmd_ctrl dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_RX_DV       (rx_dv),
    .i_RX_Byte     (rx_byte),
    .o_TX_Byte     (tx_byte),
    .i_SPI_CS_n    (cs_n),
    .o_Reg_Addr    (reg_addr),
    .o_Reg_Wr_En   (reg_wr_en),
    .o_Reg_Wr_Data (reg_wr_data),
    .o_Reg_Rd_En   (reg_rd_en),
    .i_Reg_Rd_Data (reg_rd_data),
    .o_Fifo_Rd_En  (fifo_rd_en),
    .i_Fifo_Data   (fifo_data),
    .i_Fifo_Empty  (fifo_empty),
    .o_Busy        (busy)
  );

  always #5 clk = ~clk;

  // Register file, FIFO and write log models.
  logic [7:0]  mem      [256];
  logic [7:0]  fifo_mem [16];
  logic [15:0] wr_log   [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  int          wr_cnt = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (reg_rd_en) reg_rd_data <= mem[reg_addr];
    if (fifo_rd_en) begin
      fifo_data <= fifo_mem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 1;
      pop_cnt   <= pop_cnt + 1;
    end
    if (reg_wr_en) begin
      wr_log[wr_cnt[5:0]] <= {reg_addr, reg_wr_data};
      wr_cnt              <= wr_cnt + 1;
    end
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] miso [16];
  int         nb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    miso[(nb + 1) & 15] = tx_byte;
    nb++;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (31) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    nb   = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [31:0] out_vec();
    return {4'h0, tx_byte, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, fifo_rd_en, busy};
  endfunction

  int w0;
  int p0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;
    mem[8'h00] = 8'h33;
    rst = 1'b1; cs_n = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; nb = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", out_vec(), 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("idle_status_empty", {24'h0, tx_byte}, 32'hA1);

    // Write burst 02 10 AA BB CC.
    cs_low();
    send_byte(8'h02); send_byte(8'h10); send_byte(8'hAA);
    send_byte(8'hBB); send_byte(8'hCC);
    cs_high();
    repeat (20) @(negedge clk);
    check_eq("wr_count", wr_cnt, 3);
    check_eq("wr0", {16'h0, wr_log[0]}, 32'h10AA);
    check_eq("wr1", {16'h0, wr_log[1]}, 32'h11BB);
    check_eq("wr2", {16'h0, wr_log[2]}, 32'h12CC);
    check_eq("wr_busy_after", {31'h0, busy}, 32'h0);

    // Read burst across the address wrap with a non-empty FIFO.
    fifo_mem[0] = 8'h5A;
    fifo_mem[1] = 8'h3C;
    wr_ptr = 2;
    cs_low();
    send_byte(8'h01); send_byte(8'hFE); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    cs_high();
    check_eq("rd_miso2_status", {24'h0, miso[2]}, 32'hA0);
    check_eq("rd_miso3", {24'h0, miso[3]}, 32'h11);
    check_eq("rd_miso4", {24'h0, miso[4]}, 32'h22);
    check_eq("rd_miso5_wrap", {24'h0, miso[5]}, 32'h33);
    check_eq("rd_no_pops", pop_cnt, 0);

    // Dump two entries then underrun.
    p0 = pop_cnt;
    cs_low();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00);
    cs_high();
    check_eq("dump_miso2", {24'h0, miso[2]}, 32'h5A);
    check_eq("dump_miso3", {24'h0, miso[3]}, 32'h3C);
    check_eq("dump_miso4_fill", {24'h0, miso[4]}, 32'h00);
    check_eq("dump_pops", pop_cnt - p0, 2);
    check_eq("dump_status", {24'h0, tx_byte}, 32'hA3);

    // Bad command then clear.
    cs_low(); send_byte(8'h7F); cs_high();
    check_eq("bad_status", {24'h0, tx_byte}, 32'hA7);
    cs_low(); send_byte(8'h04); cs_high();
    check_eq("clr_status", {24'h0, tx_byte}, 32'hA1);

    // Abort by CS mid-byte.
    w0 = wr_cnt;
    cs_low();
    send_byte(8'h02); send_byte(8'h20);
    repeat (10) @(negedge clk);
    cs_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("abort_cs_no_wr", wr_cnt, w0);
    check_eq("abort_cs_busy", {31'h0, busy}, 32'h0);

    // Reset in the middle of a write frame; remaining bytes ignored.
    cs_low();
    send_byte(8'h02); send_byte(8'h30);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midframe_reset_outputs", out_vec(), 32'h0);
    rst = 1'b0;
    send_byte(8'h02); send_byte(8'h41); send_byte(8'h99);
    check_eq("post_reset_ignored", wr_cnt, w0);
    check_eq("post_reset_busy", {31'h0, busy}, 32'h0);
    cs_high();
    cs_low();
    send_byte(8'h02); send_byte(8'h40); send_byte(8'h55);
    cs_high();
    check_eq("next_frame_wr_count", wr_cnt, w0 + 1);
    check_eq("next_frame_wr", {16'h0, wr_log[w0[5:0]]}, 32'h4055);

    // Last write byte's RX_DV coincides with synchronized CS high.
    w0 = wr_cnt;
    cs_low();
    send_byte(8'h02); send_byte(8'h50); send_byte(8'h61);
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = 8'h62;
    @(negedge clk);
    rx_dv = 1'b0;
    check_eq("simul_wr_strobe", {23'h0, reg_wr_en, reg_addr}, {23'h0, 1'b1, 8'h51});
    check_eq("simul_wr_data", {24'h0, reg_wr_data}, 32'h62);
    check_eq("simul_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check_eq("simul_strobe_single", {31'h0, reg_wr_en}, 32'h0);
    repeat (10) @(negedge clk);
    check_eq("simul_wr_count", wr_cnt, w0 + 2);
    check_eq("simul_idle_status", {24'h0, tx_byte}, 32'hA1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
